// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: synchronises pwm_in, measures period and high time between rising edges,
// divides to a 0..100 % duty, flags signal loss. Define PWM_CAPTURE_AVG_EN for 4-sample duty averaging.
module pwm_capture #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int PWM_FREQ        = 1_000,
    parameter int TIMEOUT_PERIODS = 2,
    localparam int NOM_CYC        = CLK_FREQ_HZ / PWM_FREQ,
    localparam int TIMEOUT_CYC    = TIMEOUT_PERIODS * NOM_CYC,
    localparam int CNT_W          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [7:0]       duty_out,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             signal_lost
);
    localparam int NUM_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sync_a;
    logic sync_s;
    logic prev_s;
    logic rise;
    logic fall;

    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             to_done;
    logic             per_reload;
    logic             timeout;

    logic             snap;
    logic             div_done;
    logic [2:0]       bit_idx;
    logic [NUM_W-1:0] rem;
    logic [6:0]       quot;
    logic [CNT_W-1:0] div_per;
    logic [CNT_W-1:0] div_high;
    logic [NUM_W-1:0] trial_div;
    logic             trial_ge;
    logic [6:0]       quot_nxt;

    // Input synchroniser plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_s <= 1'b0;
            prev_s <= 1'b0;
        end else begin
            sync_a <= pwm_in;
            sync_s <= sync_a;
            prev_s <= sync_s;
        end
    end

    assign rise = sync_s & ~prev_s;
    assign fall = ~sync_s & prev_s;

    // In IDLE a falling level restarts the loss timer so a new constant level is re-reported
    assign per_reload = rise | ((state == IDLE) & fall);
    assign timeout    = (per_cnt == CNT_MAX) & ~to_done & ~rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            high_cnt <= '0;
            to_done  <= 1'b0;
        end else begin
            if (per_reload) begin
                per_cnt <= CNT_W'(1);
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end

            if (rise) begin
                high_cnt <= CNT_W'(1);
            end else if (sync_s && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end

            if (per_reload) begin
                to_done <= 1'b0;
            end else if (timeout) begin
                to_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        div_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    snap      = 1'b1;
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (bit_idx == 3'd0) begin
                    div_done = 1'b1;
                    if (rise) begin
                        snap      = 1'b1;
                        state_nxt = DIVIDE;
                    end else begin
                        state_nxt = MEASURE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Restoring divider: one quotient bit per cycle, MSB (bit 6) first
    always_comb begin
        trial_div = NUM_W'(div_per) << bit_idx;
        trial_ge  = (rem >= trial_div);
        quot_nxt  = quot;
        if (trial_ge) begin
            quot_nxt[bit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_per  <= '0;
            div_high <= '0;
            rem      <= '0;
            quot     <= '0;
            bit_idx  <= '0;
        end else if (snap) begin
            div_per  <= per_cnt;
            div_high <= high_cnt;
            rem      <= NUM_W'(high_cnt) * NUM_W'(100);
            quot     <= '0;
            bit_idx  <= 3'd6;
        end else if (state == DIVIDE) begin
            if (trial_ge) begin
                rem <= rem - trial_div;
            end
            quot <= quot_nxt;
            if (bit_idx != 3'd0) begin
                bit_idx <= bit_idx - 3'd1;
            end
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    // hist[0] is the most recent earlier result; hist_cnt saturates at three held results
    logic [2:0][6:0] hist;
    logic [1:0]      hist_cnt;
    logic [8:0]      avg_sum;

    assign avg_sum = 9'(quot_nxt) + 9'(hist[0]) + 9'(hist[1]) + 9'(hist[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_out    <= '0;
            duty_valid  <= 1'b0;
            period_out  <= '0;
            high_out    <= '0;
            signal_lost <= 1'b0;
            hist        <= '0;
            hist_cnt    <= '0;
        end else begin
            duty_valid <= 1'b0;
            if (timeout) begin
                duty_out    <= sync_s ? 8'd100 : 8'd0;
                period_out  <= '0;
                high_out    <= '0;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b1;
                hist        <= '0;
                hist_cnt    <= '0;
            end else if (div_done) begin
                period_out  <= div_per;
                high_out    <= div_high;
                signal_lost <= 1'b0;
                hist        <= {hist[1:0], quot_nxt};
                if (hist_cnt == 2'd3) begin
                    duty_out   <= 8'(avg_sum >> 2);
                    duty_valid <= 1'b1;
                end else begin
                    hist_cnt <= hist_cnt + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_out    <= '0;
            duty_valid  <= 1'b0;
            period_out  <= '0;
            high_out    <= '0;
            signal_lost <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (timeout) begin
                duty_out    <= sync_s ? 8'd100 : 8'd0;
                period_out  <= '0;
                high_out    <= '0;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b1;
            end else if (div_done) begin
                duty_out    <= {1'b0, quot_nxt};
                period_out  <= div_per;
                high_out    <= div_high;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform segments are modelled from edge timing and arithmetic,
// then driven while every duty_valid pulse is compared against the expected queue.
module tb_pwm_capture;
    localparam int CLK_FREQ_HZ     = 1_000_000;
    localparam int PWM_FREQ        = 10_000;
    localparam int TIMEOUT_PERIODS = 2;
    localparam int T_CYC           = 200;
    localparam int CNT_W           = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [7:0]       duty_out;
    logic             duty_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             signal_lost;

    pwm_capture #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .PWM_FREQ       (PWM_FREQ),
        .TIMEOUT_PERIODS(TIMEOUT_PERIODS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_out (period_out),
        .high_out   (high_out),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  duty;
        logic [7:0]  per;
        logic [7:0]  high;
        logic        lost;
    } exp_t;

    exp_t exp_q[$];
    bit   lvl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_period(input int p, input int h);
        for (int i = 0; i < p; i++) lvl.push_back(i < h);
    endtask

    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) lvl.push_back(v);
    endtask

    function automatic bit lvl_at(input int idx);
        return (idx >= 0 && idx < lvl.size()) ? lvl[idx] : 1'b0;
    endfunction

    task automatic push_exp(input int cyc, input int duty, input int per, input int high, input bit lost);
        exp_t e;
        e.cyc  = 32'(cyc);
        e.duty = 8'(duty);
        e.per  = 8'(per);
        e.high = 8'(high);
        e.lost = lost;
        exp_q.push_back(e);
    endtask

    // Reference: times are cycles after reset release as seen past the two-stage synchroniser
    task automatic build_model();
        int n;
        int anchor, last_rise, snap_k, snap_per, snap_high, q, sum;
        bit idle, busy, s_now, s_old, rise, fall, to, done;
        int hist[$];
        n = lvl.size();
        anchor = 0; last_rise = 0; snap_k = 0; snap_per = 1; snap_high = 0;
        idle = 1'b1; busy = 1'b0;
        exp_q.delete();
        for (int k = 1; k < n; k++) begin
            s_now = lvl_at(k - 2);
            s_old = lvl_at(k - 3);
            rise  = s_now && !s_old;
            fall  = !s_now && s_old;
            to    = !rise && ((k - anchor) == T_CYC);
            done  = busy && (k == snap_k + 7) && !to;
            if (to) begin
                push_exp(k + 1, s_now ? 100 : 0, 0, 0, 1'b1);
                busy = 1'b0;
                hist.delete();
            end
            if (done) begin
                busy = 1'b0;
                q = (snap_high * 100) / snap_per;
`ifdef PWM_CAPTURE_AVG_EN
                hist.push_back(q);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4)
                    push_exp(k + 1, (hist[0] + hist[1] + hist[2] + hist[3]) / 4, snap_per, snap_high, 1'b0);
`else
                push_exp(k + 1, q, snap_per, snap_high, 1'b0);
`endif
            end
            if (rise) begin
                if (!idle && !busy) begin
                    sum = 0;
                    for (int j = last_rise; j < k; j++) sum += int'(lvl_at(j - 2));
                    snap_per  = k - last_rise;
                    snap_high = sum;
                    snap_k    = k;
                    busy      = 1'b1;
                end
                idle      = 1'b0;
                last_rise = k;
                anchor    = k;
            end else if (fall && idle) begin
                anchor = k;
            end
            if (to) idle = 1'b1;
        end
    endtask

    task automatic observe(input int t);
        exp_t e;
        if (duty_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_valid", 32'(duty_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("valid_cycle", 32'(t), e.cyc);
                check_eq("duty_out", 32'(duty_out), 32'(e.duty));
                check_eq("period_out", 32'(period_out), 32'(e.per));
                check_eq("high_out", 32'(high_out), 32'(e.high));
                check_eq("signal_lost", 32'(signal_lost), 32'(e.lost));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc == 32'(t)) begin
            check_eq("valid_missing", 32'(duty_valid), 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    // Asserts reset (checking outputs clear asynchronously), then drives the lvl waveform
    task automatic run_seg();
        int n;
        @(negedge clk);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #1;
        check_eq("rst_duty", 32'(duty_out), 32'd0);
        check_eq("rst_valid", 32'(duty_valid), 32'd0);
        check_eq("rst_period", 32'(period_out), 32'd0);
        check_eq("rst_high", 32'(high_out), 32'd0);
        check_eq("rst_lost", 32'(signal_lost), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold_valid", 32'(duty_valid), 32'd0);
        end
        build_model();
        n = lvl.size();
        rst_n = 1'b1;
        for (int t = 0; t <= n; t++) begin
            if (t > 0) begin
                @(negedge clk);
                observe(t);
            end
            if (t < n) pwm_in = lvl[t];
        end
        if (exp_q.size() != 0) check_eq("pending_results", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        lvl.delete();
    endtask

    initial begin
        int p, h;
        // Directed values, loss/recovery, then random periods
        repeat (3) add_period(100, 30);
        repeat (2) add_period(150, 100);
        repeat (2) add_period(100, 99);
        repeat (10) add_period(2, 1);
        add_level(1'b1, 250);
        add_level(1'b0, 250);
        repeat (3) add_period(100, 50);
        repeat (25) begin
            p = int'($urandom_range(190, 2));
            h = int'($urandom_range(p - 1, 1));
            add_period(p, h);
        end
        add_period(100, 50);
        run_seg();

        // Averaging sequence
        add_period(100, 20);
        add_period(100, 40);
        add_period(100, 60);
        add_period(100, 80);
        add_period(100, 50);
        run_seg();

        // Cut short mid-division: the next reset lands inside DIVIDE
        repeat (3) add_period(100, 40);
        while (lvl.size() > 205) void'(lvl.pop_back());
        run_seg();

        // Constant low after reset reports 0 % after the timeout
        add_level(1'b0, 210);
        run_seg();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiving end of the LED PWM interface: measures an incoming PWM waveform and reports its duty cycle in the same 0..100 percent units that the PWM generator accepts.
- Used for loopback self-test of the LED path and for reading external PWM sources.
- Synchronises the input, measures the period and high time between rising edges, and computes the duty with a 7-cycle sequential divider.
- Detects loss of signal (0 % / 100 % constant level).

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- PWM_FREQ, 1_000, nominal input PWM frequency; NOM_CYC = CLK_FREQ_HZ/PWM_FREQ.
- TIMEOUT_PERIODS, 2, edge-free nominal periods before signal loss; TIMEOUT_CYC = TIMEOUT_PERIODS*NOM_CYC; CNT_W = $clog2(TIMEOUT_CYC+1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- pwm_in, input, 1, asynchronous PWM input.
- duty_out, output, 8, last measured duty 0..100 percent, truncated.
- duty_valid, output, 1, one-cycle pulse when duty_out/period_out/high_out update.
- period_out, output, CNT_W, last measured period in clk cycles.
- high_out, output, CNT_W, last measured high time in clk cycles.
- signal_lost, output, 1, level; high while no rising edge seen for TIMEOUT_CYC cycles.

Behaviour:
- Reset: all outputs 0; synchroniser, counters and divider cleared; FSM in IDLE.
- Reset: asynchronous assert, synchronous deassert, effective mid-division (result discarded, no duty_valid).
- Input path: 2-FF synchroniser (reset 0), then one prev register. rise = s & !prev; fall = !s & prev. Cycle E = cycle rise is true.
- per_cnt:
  - <=1 on rise, else +1, saturating at TIMEOUT_CYC.
  - At rise, per_cnt equals cycles since the previous rise.
- high_cnt:
  - <=1 on rise, else +1 when s=1, held otherwise.
  - At rise, high_cnt equals high cycles in the previous period.
- FSM states IDLE, MEASURE, DIVIDE:
  - IDLE: waits for first rise, then -> MEASURE. Produces no result for that rise (no complete period yet).
  - MEASURE:
    - On rise: snapshot per_cnt -> div_per and high_cnt -> div_high; numerator = div_high*100 (CNT_W+7 bits); -> DIVIDE.
    - Counters keep running.
  - DIVIDE:
    - Restoring division, one quotient bit per cycle, bit 6 down to bit 0: compare remainder with div_per<<k.
    - After 7 cycles: register duty_out = quotient, period_out = div_per, high_out = div_high; duty_valid=1 in cycle E+8; clear signal_lost; -> MEASURE.
  - Rise during DIVIDE: counters restart as normal; snapshot dropped. The next result uses the following period.
- Timeout:
  - When per_cnt reaches TIMEOUT_CYC in any state (evaluated the cycle it first equals TIMEOUT_CYC):
    - duty_out = 100 if s=1 else 0; period_out=0; high_out=0; duty_valid pulse; signal_lost=1.
    - Abort any division; -> IDLE.
  - While in IDLE, fall also resets per_cnt to 1. A level change without a rise therefore re-reports after a further TIMEOUT_CYC.
  - After reset with constant input, the first report comes TIMEOUT_CYC cycles after reset.
- Arithmetic:
  - Quotient always <= 100 because high <= period; truncating (floor).
  - duty_out[7] is always 0.
  - Minimum measurable period 2 cycles.
- Simultaneous events:
  - Timeout and rise in the same cycle: rise wins; no timeout report.
  - Division completion and rise in the same cycle: result is emitted and the new snapshot is taken.

Optional Feature:
- Macro PWM_CAPTURE_AVG_EN.
- Defined:
  - Each divider result goes into a 4-entry history.
  - duty_out = floor(sum of last 4 results / 4).
  - duty_valid is suppressed until 4 results have accumulated since reset or since the last timeout.
  - period_out/high_out report the latest raw sample.
  - Timeout reports bypass averaging and clear the history.
- Undefined: every divider result is output directly; no history registers.

Test Plan:
- Params CLK_FREQ_HZ=1_000_000, PWM_FREQ=10_000 (NOM_CYC=100, TIMEOUT_CYC=200, CNT_W=8), PWM period 100, high 30, repeated -> first result on second rise: duty_out=30, period_out=100, high_out=30, duty_valid exactly at E+8, one cycle wide, signal_lost=0.
- Period 150, high 100 -> duty_out=66 (truncation); period 100, high 99 -> 99; period 2, high 1 -> 50.
- After valid periods, hold pwm_in high -> 200 cycles after last rise: duty_out=100, signal_lost=1, single duty_valid. Then drop low -> after 200 more cycles duty_out=0 with another pulse.
- From lost state, apply period 100/high 50 -> no output on first rise; result 50 on second rise; signal_lost cleared the same cycle.
- Assert rst_n low during DIVIDE -> all outputs 0 immediately, no duty_valid. After release, constant-low input -> duty_out=0 report 200 cycles after reset.
- With PWM_CAPTURE_AVG_EN, periods with highs 20, 40, 60, 80 -> first duty_valid only after 4th result, duty_out=50. Without the macro -> four valids: 20, 40, 60, 80.
